// File: rtl/core_pkg.sv
// Shared core-wide types and constants used by the front-end blocks.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-wide fetch queue: circular buffer between fetch and decode with
// in-order packing of valid slots, thermometer-coded dequeue and flush.
module fetch_queue
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [1:0]               enq_valid_i,
  input  logic [XLEN-1:0]          enq_pc0_i,
  input  logic [XLEN-1:0]          enq_pc1_i,
  input  logic [XLEN-1:0]          enq_instr0_i,
  input  logic [XLEN-1:0]          enq_instr1_i,
  output logic                     stall_o,
  output logic [1:0]               deq_valid_o,
  output logic [XLEN-1:0]          deq_pc0_o,
  output logic [XLEN-1:0]          deq_pc1_o,
  output logic [XLEN-1:0]          deq_instr0_o,
  output logic [XLEN-1:0]          deq_instr1_o,
  input  logic [1:0]               deq_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_plus1;
  logic [PW-1:0]   tail_plus1;
  logic [CW-1:0]   count;
  logic            enq_ok;
  logic [1:0]      n_enq;
  logic [1:0]      n_deq;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  assign head_plus1 = head + PW'(1);
  assign tail_plus1 = tail + PW'(1);

  // Backpressure looks only at the registered count so fetch sees a stable
  // signal; same-cycle dequeues never open room early.
  assign stall_o     = (CW'(DEPTH) - count) < CW'(2);
  assign deq_valid_o = {count >= CW'(2), count != '0};

  assign enq_ok = !stall_o && !flush_i;
  assign n_enq  = enq_ok ? ({1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]}) : 2'd0;

  always_comb begin
    n_deq = 2'd0;
    if (deq_ready_i == 2'b11 && deq_valid_o == 2'b11) begin
      n_deq = 2'd2;
    end else if (deq_ready_i[0] && deq_valid_o[0]) begin
      n_deq = 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Valid slots are packed in program order starting at tail, so a lone
  // slot1 lands at tail just like a lone slot0 would.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (enq_ok) begin
      case (enq_valid_i)
        2'b01: begin
          mem_pc[tail]    <= enq_pc0_i;
          mem_instr[tail] <= enq_instr0_i;
        end
        2'b10: begin
          mem_pc[tail]    <= enq_pc1_i;
          mem_instr[tail] <= enq_instr1_i;
        end
        2'b11: begin
          mem_pc[tail]          <= enq_pc0_i;
          mem_instr[tail]       <= enq_instr0_i;
          mem_pc[tail_plus1]    <= enq_pc1_i;
          mem_instr[tail_plus1] <= enq_instr1_i;
        end
        default: ;
      endcase
    end
  end

  assign deq_pc0_o    = mem_pc[head];
  assign deq_instr0_o = mem_instr[head];
  assign deq_pc1_o    = mem_pc[head_plus1];
  assign deq_instr1_o = mem_instr[head_plus1];
  assign count_o      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fetch_queue;
  import core_pkg::*;

  localparam int DEPTH = 8;
  localparam int XL    = core_pkg::XLEN;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [1:0]    enq_valid;
  logic [XL-1:0] enq_pc0, enq_pc1, enq_instr0, enq_instr1;
  logic          stall;
  logic [1:0]    deq_valid;
  logic [XL-1:0] deq_pc0, deq_pc1, deq_instr0, deq_instr1;
  logic [1:0]    deq_ready;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  fq_entry_t model_q[$];

  typedef struct {
    logic          flush;
    logic [1:0]    ev;
    logic [XL-1:0] pc0;
    logic [XL-1:0] pc1;
    logic [1:0]    rdy;
    int            exp_count;
    logic [1:0]    exp_valid;
    logic          exp_stall;
    logic [XL-1:0] exp_pc0;
    logic [XL-1:0] exp_pc1;
  } vec_t;

  vec_t vecs[10];

  fetch_queue #(.XLEN(XL), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .enq_valid_i (enq_valid),
    .enq_pc0_i   (enq_pc0),
    .enq_pc1_i   (enq_pc1),
    .enq_instr0_i(enq_instr0),
    .enq_instr1_i(enq_instr1),
    .stall_o     (stall),
    .deq_valid_o (deq_valid),
    .deq_pc0_o   (deq_pc0),
    .deq_pc1_o   (deq_pc1),
    .deq_instr0_o(deq_instr0),
    .deq_instr1_o(deq_instr1),
    .deq_ready_i (deq_ready),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XL-1:0] instr_of(input logic [XL-1:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue semantics: pop what decode takes, then append accepted slots in order.
  task automatic model_step(input logic fl, input logic [1:0] ev,
                            input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                            input logic [1:0] rdy);
    int  sz;
    int  nd;
    bit  full_ish;
    sz = model_q.size();
    full_ish = (DEPTH - sz) < 2;
    if (fl) begin
      model_q.delete();
    end else begin
      nd = 0;
      if (rdy == 2'b11 && sz >= 2) nd = 2;
      else if (rdy[0] && sz >= 1) nd = 1;
      repeat (nd) void'(model_q.pop_front());
      if (!full_ish) begin
        if (ev[0]) model_q.push_back('{pc: p0, instr: instr_of(p0)});
        if (ev[1]) model_q.push_back('{pc: p1, instr: instr_of(p1)});
      end
    end
  endtask

  task automatic apply_stimulus(input logic fl, input logic [1:0] ev,
                                input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                                input logic [1:0] rdy);
    flush      = fl;
    enq_valid  = ev;
    enq_pc0    = p0;
    enq_pc1    = p1;
    enq_instr0 = instr_of(p0);
    enq_instr1 = instr_of(p1);
    deq_ready  = rdy;
    model_step(fl, ev, p0, p1, rdy);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    enq_valid = 2'b00;
    deq_ready = 2'b00;
  endtask

  task automatic check_output(input string tag);
    int sz;
    sz = model_q.size();
    check_val({tag, " count"}, 32'(count), 32'(sz));
    check_val({tag, " valid"}, 32'(deq_valid), (sz >= 2) ? 32'd3 : ((sz == 1) ? 32'd1 : 32'd0));
    check_val({tag, " stall"}, 32'(stall), ((DEPTH - sz) < 2) ? 32'd1 : 32'd0);
    if (sz >= 1) begin
      check_val({tag, " pc0"}, deq_pc0, model_q[0].pc);
      check_val({tag, " instr0"}, deq_instr0, model_q[0].instr);
    end
    if (sz >= 2) begin
      check_val({tag, " pc1"}, deq_pc1, model_q[1].pc);
      check_val({tag, " instr1"}, deq_instr1, model_q[1].instr);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b11, 32'h00, 32'h04, 2'b00, 2, 2'b11, 1'b0, 32'h00, 32'h04};
    vecs[1] = '{1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 0, 2'b00, 1'b0, 32'h00, 32'h00};
    vecs[2] = '{1'b0, 2'b10, 32'h00, 32'h14, 2'b00, 1, 2'b01, 1'b0, 32'h14, 32'h00};
    vecs[3] = '{1'b0, 2'b11, 32'h20, 32'h24, 2'b00, 3, 2'b11, 1'b0, 32'h14, 32'h20};
    vecs[4] = '{1'b0, 2'b01, 32'h28, 32'h00, 2'b00, 4, 2'b11, 1'b0, 32'h14, 32'h20};
    vecs[5] = '{1'b0, 2'b00, 32'h00, 32'h00, 2'b10, 4, 2'b11, 1'b0, 32'h14, 32'h20};
    vecs[6] = '{1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 3, 2'b11, 1'b0, 32'h20, 32'h24};
    vecs[7] = '{1'b0, 2'b11, 32'h30, 32'h34, 2'b00, 5, 2'b11, 1'b0, 32'h20, 32'h24};
    vecs[8] = '{1'b1, 2'b11, 32'h50, 32'h54, 2'b11, 0, 2'b00, 1'b0, 32'h00, 32'h00};
    vecs[9] = '{1'b0, 2'b01, 32'h40, 32'h00, 2'b01, 1, 2'b01, 1'b0, 32'h40, 32'h00};

    rst_n = 1'b0; flush = 1'b0; enq_valid = 2'b00; deq_ready = 2'b00;
    enq_pc0 = '0; enq_pc1 = '0; enq_instr0 = '0; enq_instr1 = '0;
    #12;
    check_val("reset count", 32'(count), 32'd0);
    check_val("reset valid", 32'(deq_valid), 32'd0);
    check_val("reset stall", 32'(stall), 32'd0);
    check_val("reset pc0", deq_pc0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].flush, vecs[i].ev, vecs[i].pc0, vecs[i].pc1, vecs[i].rdy);
      check_val($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check_val($sformatf("vec%0d valid", i), 32'(deq_valid), 32'(vecs[i].exp_valid));
      check_val($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      if (vecs[i].exp_count >= 1) check_val($sformatf("vec%0d pc0", i), deq_pc0, vecs[i].exp_pc0);
      if (vecs[i].exp_count >= 2) check_val($sformatf("vec%0d pc1", i), deq_pc1, vecs[i].exp_pc1);
      check_output($sformatf("vec%0d model", i));
    end

    // Asynchronous reset in the middle of operation.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_val("midreset count", 32'(count), 32'd0);
    check_val("midreset valid", 32'(deq_valid), 32'd0);
    check_val("midreset pc0", deq_pc0, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to 7 and confirm further enqueues are held off.
    apply_stimulus(1'b0, 2'b01, 32'h100, 32'h0, 2'b00);
    check_val("post-reset pc0", deq_pc0, 32'h100);
    apply_stimulus(1'b0, 2'b11, 32'h104, 32'h108, 2'b00);
    apply_stimulus(1'b0, 2'b11, 32'h10C, 32'h110, 2'b00);
    apply_stimulus(1'b0, 2'b11, 32'h114, 32'h118, 2'b00);
    check_val("fill7 stall", 32'(stall), 32'd1);
    apply_stimulus(1'b0, 2'b11, 32'h200, 32'h204, 2'b00);
    check_val("fill7 held count", 32'(count), 32'd7);
    check_output("fill7");

    // Drain to 3, then enqueue and dequeue together across the 7->0 wrap.
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    check_val("drain count", 32'(count), 32'd3);
    apply_stimulus(1'b0, 2'b11, 32'h300, 32'h304, 2'b11);
    check_val("wrap1 count", 32'(count), 32'd3);
    check_val("wrap1 pc0", deq_pc0, 32'h118);
    check_val("wrap1 pc1", deq_pc1, 32'h300);
    apply_stimulus(1'b0, 2'b11, 32'h308, 32'h30C, 2'b11);
    check_val("wrap2 count", 32'(count), 32'd3);
    check_val("wrap2 pc0", deq_pc0, 32'h304);
    check_val("wrap2 pc1", deq_pc1, 32'h308);
    check_output("wrap");

    // Reach exactly full from 6 with a paired enqueue.
    apply_stimulus(1'b0, 2'b11, 32'h400, 32'h404, 2'b00);
    apply_stimulus(1'b0, 2'b01, 32'h408, 32'h0, 2'b00);
    check_val("six stall", 32'(stall), 32'd0);
    apply_stimulus(1'b0, 2'b11, 32'h40C, 32'h410, 2'b00);
    check_val("full count", 32'(count), 32'd8);
    check_val("full stall", 32'(stall), 32'd1);
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    check_val("full-1 stall", 32'(stall), 32'd1);
    check_output("full");

    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom_range(0, 19) == 0), 2'($urandom), $urandom, $urandom, 2'($urandom));
      check_output($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
